alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : ALU execute stage. Single-cycle logic/arith ops, plus a
//            shift-add unsigned multiplier and a restoring unsigned divider
//            that each take one iteration per clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             illegal,
    output logic             dz
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_MULU, OP_DIVU, OP_ILL
    } op_t;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    op_t                w_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor
    logic [WIDTH-1:0]   r_hi;        // partial product high half / remainder
    logic [WIDTH-1:0]   r_lo;        // multiplier bits / dividend-quotient
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_zero;
    logic               r_illegal;
    logic               r_dz;

    logic [WIDTH-1:0]   w_alu_res;
    logic               w_accept;
    logic               w_last;
    logic               w_div_by_zero;
    logic               w_multi;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_lo_n;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_r_n;
    logic [WIDTH-1:0]   w_div_q_n;

    assign w_accept      = start && (r_state == ST_IDLE);
    assign w_last        = (r_cnt == c_last_iter);
    assign w_div_by_zero = (w_op == OP_DIVU) && (b == '0);
    assign w_multi       = (w_op == OP_MULU) || ((w_op == OP_DIVU) && (b != '0));

    // Operation decode: main opcode directly, or the function field for R-type
    always_comb begin
        w_op = OP_ILL;
        if (alu_op != 3'b111) begin
            case (alu_op)
                3'b000:  w_op = OP_ADD;
                3'b001:  w_op = OP_SUB;
                3'b010:  w_op = OP_AND;
                3'b011:  w_op = OP_OR;
                3'b100:  w_op = OP_XOR;
                3'b101:  w_op = OP_NOR;
                3'b110:  w_op = OP_SLT;
                default: w_op = OP_ILL;
            endcase
        end else begin
            case (func)
                6'b100000: w_op = OP_ADD;
                6'b100010: w_op = OP_SUB;
                6'b100100: w_op = OP_AND;
                6'b100101: w_op = OP_OR;
                6'b100110: w_op = OP_XOR;
                6'b100111: w_op = OP_NOR;
                6'b101010: w_op = OP_SLT;
                6'b101011: w_op = OP_SLTU;
                6'b000000: w_op = OP_ADD;
                6'b011001: w_op = OP_MULU;
                6'b011011: w_op = OP_DIVU;
                default:   w_op = OP_ILL;
            endcase
        end
    end

    // Single-cycle result; divide-by-zero saturates the quotient to all ones
    always_comb begin
        w_alu_res = '0;
        case (w_op)
            OP_ADD:  w_alu_res = a + b;
            OP_SUB:  w_alu_res = a - b;
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_NOR:  w_alu_res = ~(a | b);
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_DIVU: w_alu_res = '1;
            default: w_alu_res = '0;
        endcase
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : '0)};
        w_mul_lo_n  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        w_div_sh    = {r_hi, r_lo[WIDTH-1]};
        w_div_trial = w_div_sh - {1'b0, r_opnd};
        w_div_ok    = ~w_div_trial[WIDTH];
        w_div_r_n   = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
        w_div_q_n   = {r_lo[WIDTH-2:0], w_div_ok};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_op == OP_MULU)  w_state_nxt = ST_MUL;
                    else if (w_multi)     w_state_nxt = ST_DIV;
                    else                  w_state_nxt = ST_DONE;
                end
            end
            ST_MUL:  if (w_last) w_state_nxt = ST_DONE;
            ST_DIV:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result/flag registration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_opnd      <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_dz        <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_hi  <= '0;
            if (w_op == OP_DIVU) begin
                r_opnd <= b;
                r_lo   <= a;
            end else begin
                r_opnd <= a;
                r_lo   <= b;
            end
            if (!w_multi) begin
                r_result    <= w_alu_res;
                r_result_hi <= w_div_by_zero ? a : '0;
                r_zero      <= (w_alu_res == '0);
                r_illegal   <= (w_op == OP_ILL);
                r_dz        <= w_div_by_zero;
            end
        end else if (r_state == ST_MUL) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_mul_sum[WIDTH:1];
            r_lo  <= w_mul_lo_n;
            if (w_last) begin
                r_result    <= w_mul_lo_n;
                r_result_hi <= w_mul_sum[WIDTH:1];
                r_zero      <= (w_mul_lo_n == '0);
                r_illegal   <= 1'b0;
                r_dz        <= 1'b0;
            end
        end else if (r_state == ST_DIV) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_div_r_n;
            r_lo  <= w_div_q_n;
            if (w_last) begin
                r_result    <= w_div_q_n;
                r_result_hi <= w_div_r_n;
                r_zero      <= (w_div_q_n == '0);
                r_illegal   <= 1'b0;
                r_dz        <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
    assign dz        = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Self-checking bench for alu_exec_unit (WIDTH=32): directed
//            vectors, randomized ops against an arithmetic reference model,
//            and a reset-abort sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   alu_op;
    logic [5:0]   func;
    logic [W-1:0] a, b;
    logic         busy, done, zero, illegal, dz;
    logic [W-1:0] result, result_hi;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .func(func),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .result_hi(result_hi), .zero(zero), .illegal(illegal), .dz(dz)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         il;
        logic         d;
        int           lat;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [5:0]   fn;
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t         e;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [5:0] fn,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] res, input logic [W-1:0] hi,
                                input logic z, input logic il, input logic d, input int lat);
        vec_t v;
        v.op = op; v.fn = fn; v.x = x; v.y = y;
        v.e.res = res; v.e.hi = hi; v.e.z = z; v.e.il = il; v.e.d = d; v.e.lat = lat;
        return v;
    endfunction

    // Reference model: plain arithmetic on the decoded operation
    function automatic exp_t model(input logic [2:0] op, input logic [5:0] fn,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t           e;
        int             k;
        logic [2*W-1:0] p;
        e.res = '0; e.hi = '0; e.il = 1'b0; e.d = 1'b0; e.lat = 1;
        if (op != 3'b111) k = int'(op);
        else begin
            case (fn)
                6'h20:   k = 0;
                6'h22:   k = 1;
                6'h24:   k = 2;
                6'h25:   k = 3;
                6'h26:   k = 4;
                6'h27:   k = 5;
                6'h2A:   k = 6;
                6'h2B:   k = 7;
                6'h00:   k = 0;
                6'h19:   k = 8;
                6'h1B:   k = 9;
                default: k = -1;
            endcase
        end
        case (k)
            0: e.res = x + y;
            1: e.res = x - y;
            2: e.res = x & y;
            3: e.res = x | y;
            4: e.res = x ^ y;
            5: e.res = ~(x | y);
            6: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
            7: e.res = (x < y) ? 1 : 0;
            8: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.hi  = p[2*W-1:W];
                e.res = p[W-1:0];
                e.lat = W + 1;
            end
            9: begin
                if (y == 0) begin
                    e.res = '1; e.hi = x; e.d = 1'b1;
                end else begin
                    e.res = x / y; e.hi = x % y; e.lat = W + 1;
                end
            end
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Issue one op, scramble inputs afterwards, optionally pulse start while busy
    task automatic do_op(input logic [2:0] op, input logic [5:0] fn,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit noise, output exp_t got);
        @(negedge clk);
        start = 1'b1; alu_op = op; func = fn; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        alu_op = 3'($urandom); func = 6'($urandom);
        got.lat = 1;
        while (done !== 1'b1 && got.lat < 200) begin
            if (noise) start = 1'($urandom);
            @(negedge clk);
            got.lat++;
        end
        start   = 1'b0;
        got.res = result; got.hi = result_hi;
        got.z   = zero;   got.il = illegal; got.d = dz;
        chk("busy_during_done", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("done_single_cycle", {63'd0, done}, 64'd0);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic cmp(input string tag, input exp_t got, input exp_t e);
        chk({tag, "_result"},    {32'd0, got.res}, {32'd0, e.res});
        chk({tag, "_result_hi"}, {32'd0, got.hi},  {32'd0, e.hi});
        chk({tag, "_zero"},      {63'd0, got.z},   {63'd0, e.z});
        chk({tag, "_illegal"},   {63'd0, got.il},  {63'd0, e.il});
        chk({tag, "_dz"},        {63'd0, got.d},   {63'd0, e.d});
        chk({tag, "_latency"},   64'(got.lat),     64'(e.lat));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      {63'd0, busy},       64'd0);
        chk({tag, "_done"},      {63'd0, done},       64'd0);
        chk({tag, "_result"},    {32'd0, result},     64'd0);
        chk({tag, "_result_hi"}, {32'd0, result_hi},  64'd0);
        chk({tag, "_zero"},      {63'd0, zero},       64'd0);
        chk({tag, "_illegal"},   {63'd0, illegal},    64'd0);
        chk({tag, "_dz"},        {63'd0, dz},         64'd0);
    endtask

    vec_t       vecs[15];
    logic [5:0] fns[12];
    exp_t       got;
    exp_t       e;
    int         n_done;

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_op = '0; func = '0; a = '0; b = '0;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = mk(3'b111, 6'b100010, 32'd5, 32'd5, 32'd0, 32'd0, 1, 0, 0, 1);
        vecs[1]  = mk(3'b111, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 0, 0, 0, 1);
        vecs[2]  = mk(3'b111, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1, 0, 0, 1);
        vecs[3]  = mk(3'b111, 6'b011001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 0, 0, 0, 33);
        vecs[4]  = mk(3'b111, 6'b011011, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, 33);
        vecs[5]  = mk(3'b111, 6'b011011, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 0, 0, 1, 1);
        vecs[6]  = mk(3'b111, 6'b111111, 32'd12, 32'd34, 32'd0, 32'd0, 1, 1, 0, 1);
        vecs[7]  = mk(3'b011, 6'b000000, 32'hF0, 32'h0F, 32'hFF, 32'd0, 0, 0, 0, 1);
        vecs[8]  = mk(3'b000, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1, 0, 0, 1);
        vecs[9]  = mk(3'b001, 6'b000000, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 1);
        vecs[10] = mk(3'b101, 6'b000000, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 1);
        vecs[11] = mk(3'b110, 6'b000000, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 0, 0, 1);
        vecs[12] = mk(3'b111, 6'b011011, 32'd7, 32'd100, 32'd0, 32'd7, 1, 0, 0, 33);
        vecs[13] = mk(3'b111, 6'b011001, 32'd0, 32'd5, 32'd0, 32'd0, 1, 0, 0, 33);
        vecs[14] = mk(3'b111, 6'b000000, 32'd3, 32'd4, 32'd7, 32'd0, 0, 0, 0, 1);

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].op, vecs[i].fn, vecs[i].x, vecs[i].y, 1'b1, got);
            cmp($sformatf("vec%0d", i), got, vecs[i].e);
        end

        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                6'h00, 6'h19, 6'h1B, 6'h3F};
        for (int i = 0; i < 150; i++) begin
            logic [2:0]   op;
            logic [5:0]   fn;
            logic [W-1:0] x, y;
            int           sel;
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 12);
            fn  = (sel == 12) ? 6'($urandom) : fns[sel];
            x   = $urandom;
            y   = $urandom;
            if ((i % 7) == 0) y = '0;
            if ((i % 11) == 0) y = y >> $urandom_range(0, 31);
            e = model(op, fn, x, y);
            do_op(op, fn, x, y, 1'b1, got);
            cmp($sformatf("rnd%0d_op%0d_fn%0h", i, op, fn), got, e);
        end

        // Reset in the middle of a multiply: leave non-zero results first
        do_op(3'b000, 6'd0, 32'd3, 32'd4, 1'b0, got);
        chk("pre_abort_result", {32'd0, got.res}, 64'd7);
        @(negedge clk);
        start = 1'b1; alu_op = 3'b111; func = 6'b011001; a = 32'hFFFF_FFFF; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        n_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        do_op(3'b000, 6'd0, 32'd3, 32'd4, 1'b0, got);
        cmp("post_reset_add", got, model(3'b000, 6'd0, 32'd3, 32'd4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
